ps2_tx: RTL and testbench
=========================

// Module: ps2_tx
// PURPOSE
//  PS/2 host-to-device transmitter (keyboard commands: LEDs, reset, typematic) for PicoSoC.
//  Write-side counterpart of the PS/2 receive path; shares the open-collector lines through pad buffers.
//  Frame: clock inhibit, start, 8 data LSB-first, odd parity, stop, device ACK.
//  Asserts tx_active so the receive path ignores its own frame.
// PARAMETERS
//  INHIBIT_CYCLES  1200   clk cycles ps2_clk is held low before start (>=100us; 1200 @12MHz)
//  TIMEOUT_CYCLES  24000  max clk cycles between device clock falls before abort (2ms @12MHz)
//  FILTER_LEN      8      ps2_clk debounce depth (samples)
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   synchronous active-low reset
//  ps2_clk_i    in   1   PS/2 clock pad input (async)
//  ps2_data_i   in   1   PS/2 data pad input (async)
//  ps2_clk_oe   out  1   1 = pull PS/2 clock low, 0 = release
//  ps2_data_oe  out  1   1 = pull PS/2 data low, 0 = release
//  reg_dat_we   in   1   write strobe; byte in reg_dat_di[7:0]
//  reg_dat_di   in   32  write data; [31:8] ignored
//  reg_dat_wait out  1   = reg_dat_we && busy; write stalls until idle
//  reg_sta_do   out  32  {29'b0, err, ack, busy}
//  tx_active    out  1   = busy; gates receiver
// BEHAVIOUR
//  Reset: both oe=0, busy=0, ack=0, err=0, state IDLE. Reset mid-frame releases lines in one cycle.
//  Sync: ps2_data_i through 2 flops; ps2_clk_i through 2 flops, then FILTER_LEN shift register.
//   Filtered clk goes 1 when all samples are 1 and 0 when all are 0; otherwise holds.
//   fall = filtered 1->0 transition, a 1-cycle pulse.
//  Write accepted when reg_dat_we && !busy: latch byte, parity = ~^byte, ack<=0, err<=0, busy<=1.
//  States:
//   IDLE     oe=00. Enter INHIBIT on accept.
//   INHIBIT  clk_oe=1; count INHIBIT_CYCLES, then START.
//   START    clk_oe=1, data_oe=1 for 1 cycle. Then clk_oe=0 (data_oe stays 1), bitcnt=0, enter XFER.
//   XFER     on each fall: bitcnt 0..7 drive data_oe=~byte[bitcnt]; 8 drive data_oe=~parity;
//            9 data_oe=0 (stop). bitcnt++. After the 10th fall go to ACK.
//   ACK      on next fall sample synced data: 0 -> ack<=1, else err<=1. Go to RELEASE.
//   RELEASE  wait for filtered clk=1 and synced data=1, then IDLE, busy<=0.
//  Timeout: cycle counter cleared on entering START and on each fall.
//   In XFER, ACK or RELEASE, reaching TIMEOUT_CYCLES: oe=00, err<=1, busy<=0, IDLE.
//  Device never clocks -> timeout. Data stuck low in RELEASE -> timeout.
//  Data changes only on fall (device samples on rising); oe never toggles except at fall or state entry.
//  ack/err are sticky until the next accepted write. The counter is wide enough for max(INHIBIT,TIMEOUT).
//  Write with busy=1: no effect on frame; reg_dat_wait=1 each such cycle; accepted on first idle cycle.
//  Write in same cycle as frame end (busy falling): not accepted that cycle (wait=1), accepted next.
// TESTING (INHIBIT_CYCLES=16, TIMEOUT_CYCLES=200, FILTER_LEN=4, open-collector device model)
//  Write 0xED; model clocks 11 periods, ACKs -> clk_oe high exactly 16 cycles, start 0;
//   bits sampled on rising 1,0,1,1,0,1,1,1, parity 1, stop 1; reg_sta_do=2 (ack, not busy).
//  Write 0x00; model sends no ACK (data stays high) -> parity bit 1, reg_sta_do=4 (err), oe=00.
//  Write 0xFF; model never clocks -> 200 cycles after START, oe=00, err=1, busy=0.
//  Write 0xF4, then a second write of 0x55 during frame -> wait=1 until first frame done;
//   0x55 then sent with parity 1.
//  resetn=0 during bit 4 of 0xAA -> next cycle oe=00, reg_sta_do=0; a new write of 0xAA completes with ack=1.
//  Glitch: 2-cycle low pulse on ps2_clk_i in XFER -> no fall counted, frame completes normally.

Source files
------------

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device transmitter
//
// Sends one command byte to a PS/2 device: clock inhibit, start bit,
// 8 data bits LSB-first, odd parity, stop bit, then samples the device ACK.
// Both PS/2 lines are open-collector; the *_oe outputs pull them low.
//
// Ports:
//   clk, resetn        system clock, synchronous active-low reset
//   ps2_clk_i          PS/2 clock pad input (asynchronous)
//   ps2_data_i         PS/2 data pad input (asynchronous)
//   ps2_clk_oe         1 = pull PS/2 clock low
//   ps2_data_oe        1 = pull PS/2 data low
//   reg_dat_we         write strobe, byte in reg_dat_di[7:0]
//   reg_dat_di         write data ([31:8] ignored)
//   reg_dat_wait       write stalled because a frame is in progress
//   reg_sta_do         {29'b0, err, ack, busy}
//   tx_active          frame in progress; lets the receiver ignore it
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int FILTER_LEN     = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    input  logic        reg_dat_we,
    input  logic [31:0] reg_dat_di,
    output logic        reg_dat_wait,
    output logic [31:0] reg_sta_do,
    output logic        tx_active
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_XFER, S_ACK, S_RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic                  clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  filt_clk_q;
    logic [7:0]            byte_q;
    logic                  parity_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            bitcnt_q;
    logic                  data_oe_q;
    logic                  ack_q, err_q, busy_q;

    logic fall, accept, inhibit_done, timeout, frame_live;
    logic unused_hi;

    assign unused_hi = ^reg_dat_di[31:8];

    // Line idles high, so the synchronisers and filter start at 1 to avoid
    // a spurious fall right after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= '1;
            filt_clk_q  <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
            filt_q      <= {filt_q[FILTER_LEN-2:0], clk_sync_q};
            if (&filt_q)
                filt_clk_q <= 1'b1;
            else if (~|filt_q)
                filt_clk_q <= 1'b0;
        end
    end

    assign fall         = filt_clk_q && ~|filt_q;
    assign accept       = reg_dat_we && !busy_q;
    assign inhibit_done = (cnt_q == CNT_W'(INHIBIT_CYCLES - 1));
    assign frame_live   = (state_q == S_XFER) || (state_q == S_ACK) || (state_q == S_RELEASE);
    // A fall in the same cycle restarts the window, so it wins over timeout.
    assign timeout      = frame_live && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !fall;

    always_ff @(posedge clk) begin
        if (!resetn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_INHIBIT;
            S_INHIBIT: if (inhibit_done) state_d = S_START;
            S_START:   state_d = S_XFER;
            S_XFER: begin
                if (timeout)
                    state_d = S_IDLE;
                else if (fall && bitcnt_q == 4'd9)
                    state_d = S_ACK;
            end
            S_ACK: begin
                if (timeout)
                    state_d = S_IDLE;
                else if (fall)
                    state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (timeout || (filt_clk_q && data_sync_q))
                    state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (state_q)
            S_INHIBIT: ps2_clk_oe = 1'b1;
            S_START: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
            end
            S_XFER:    ps2_data_oe = data_oe_q;
            default: begin
                ps2_clk_oe  = 1'b0;
                ps2_data_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            byte_q    <= 8'h00;
            parity_q  <= 1'b0;
            cnt_q     <= '0;
            bitcnt_q  <= 4'd0;
            data_oe_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            if (accept) begin
                byte_q   <= reg_dat_di[7:0];
                parity_q <= ~^reg_dat_di[7:0];
                ack_q    <= 1'b0;
                err_q    <= 1'b0;
            end
            case (state_q)
                S_INHIBIT: cnt_q <= inhibit_done ? '0 : cnt_q + CNT_W'(1);
                S_START: begin
                    cnt_q     <= cnt_q + CNT_W'(1);
                    bitcnt_q  <= 4'd0;
                    data_oe_q <= 1'b1;
                end
                S_XFER, S_ACK, S_RELEASE: cnt_q <= fall ? '0 : cnt_q + CNT_W'(1);
                default:   cnt_q <= '0;
            endcase
            // New bit goes out on the fall so it is stable at the device's rising edge.
            if (state_q == S_XFER && fall) begin
                bitcnt_q <= bitcnt_q + 4'd1;
                if (bitcnt_q < 4'd8)
                    data_oe_q <= ~byte_q[bitcnt_q[2:0]];
                else if (bitcnt_q == 4'd8)
                    data_oe_q <= ~parity_q;
                else
                    data_oe_q <= 1'b0;
            end
            if (state_q == S_ACK && fall) begin
                if (data_sync_q)
                    err_q <= 1'b1;
                else
                    ack_q <= 1'b1;
            end
            if (timeout)
                err_q <= 1'b1;
        end
    end

    assign reg_dat_wait = reg_dat_we && busy_q;
    assign reg_sta_do   = {29'b0, err_q, ack_q, busy_q};
    assign tx_active    = busy_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx with open-collector device model
module tb_ps2_tx;

    localparam int INH  = 16;
    localparam int TMO  = 200;
    localparam int FL   = 4;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;
    logic        ps2_clk_oe, ps2_data_oe;
    logic        reg_dat_we = 1'b0;
    logic [31:0] reg_dat_di = 32'h0;
    logic        reg_dat_wait;
    logic [31:0] reg_sta_do;
    logic        tx_active;
    logic        clk_line, data_line;

    assign clk_line  = dev_clk & ~ps2_clk_oe;
    assign data_line = dev_data & ~ps2_data_oe;

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .reg_dat_we  (reg_dat_we),
        .reg_dat_di  (reg_dat_di),
        .reg_dat_wait(reg_dat_wait),
        .reg_sta_do  (reg_sta_do),
        .tx_active   (tx_active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Length of the most recent run of clock-inhibit-only cycles.
    int inh_run  = 0;
    int last_inh = 0;
    always @(negedge clk) begin
        if (ps2_clk_oe && !ps2_data_oe)
            inh_run++;
        else if (inh_run != 0) begin
            last_inh = inh_run;
            inh_run  = 0;
        end
    end

    task automatic host_write(input logic [7:0] b);
        logic [23:0] hi;
        hi = $urandom;
        @(posedge clk);
        #1 reg_dat_we = 1'b1;
        reg_dat_di = {hi, b};
        @(posedge clk);
        #1 reg_dat_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (tx_active && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) expired(name);
    endtask

    // Device side of one frame: sees the start bit, clocks 10 bits sampling on
    // rising edges, then an 11th clock carrying the ACK (or not).
    task automatic device_frame(input bit send_ack, input bit glitch, input int abort_at,
                                output logic st, output logic [7:0] bits,
                                output logic par, output logic sp);
        int n = 0;
        st = 1'b1; bits = 8'h00; par = 1'b0; sp = 1'b0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            expired("start_seen");
            return;
        end
        st = data_line;
        repeat (15) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 dev_clk = 1'b0;
            if (i == abort_at) begin
                repeat (HALF / 2) @(posedge clk);
                chk("busy_before_reset", {31'b0, tx_active}, 32'd1);
                #1 resetn = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("reset_mid_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
                chk("reset_mid_sta", reg_sta_do, 32'd0);
                resetn  = 1'b1;
                dev_clk = 1'b1;
                return;
            end
            repeat (HALF) @(posedge clk);
            #1 dev_clk = 1'b1;
            if (i < 8)       bits[i] = data_line;
            else if (i == 8) par = data_line;
            else             sp = data_line;
            if (glitch && i == 5) begin
                repeat (HALF / 2) @(posedge clk);
                #1 dev_clk = 1'b0;
                repeat (2) @(posedge clk);
                #1 dev_clk = 1'b1;
                repeat (HALF / 2) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
        end
        #1 if (send_ack) dev_data = 1'b0;
        repeat (5) @(posedge clk);
        #1 dev_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 dev_clk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 dev_data = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          ack;
        bit          glitch;
        logic        exp_par;
        logic [31:0] exp_sta;
    } vec_t;

    vec_t tbl[4];

    task automatic run_frame(input string tag, input logic [7:0] b, input bit ack, input bit glitch,
                             input logic exp_par, input logic [31:0] exp_sta);
        logic       st, par, sp;
        logic [7:0] bits;
        host_write(b);
        device_frame(ack, glitch, -1, st, bits, par, sp);
        wait_idle({tag, "_idle"});
        @(negedge clk);
        chk({tag, "_start"}, {31'b0, st}, 32'd0);
        chk({tag, "_bits"}, {24'b0, bits}, {24'b0, b});
        chk({tag, "_parity"}, {31'b0, par}, {31'b0, exp_par});
        chk({tag, "_stop"}, {31'b0, sp}, 32'd1);
        chk({tag, "_sta"}, reg_sta_do, exp_sta);
        chk({tag, "_inhibit_len"}, last_inh, INH);
        chk({tag, "_oe_idle"}, {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        logic       st, par, sp, st2, par2, sp2;
        logic [7:0] bits, bits2;
        int         n, nwait, mism;

        tbl[0] = '{8'hED, 1'b1, 1'b0, 1'b1, 32'd2};
        tbl[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 32'd4};
        tbl[2] = '{8'hF4, 1'b1, 1'b1, 1'b0, 32'd2};
        tbl[3] = '{8'hAA, 1'b1, 1'b0, 1'b1, 32'd2};

        repeat (4) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset_oe", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("reset_sta", reg_sta_do, 32'd0);
        chk("reset_active", {31'b0, tx_active}, 32'd0);
        chk("reset_wait", {31'b0, reg_dat_wait}, 32'd0);

        for (int i = 0; i < 4; i++)
            run_frame($sformatf("tbl%0d", i), tbl[i].b, tbl[i].ack, tbl[i].glitch,
                      tbl[i].exp_par, tbl[i].exp_sta);

        // Device never clocks: abort exactly TMO cycles after the START cycle.
        host_write(8'hFF);
        n = 0;
        while (!ps2_data_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) expired("tmo_start");
        n = 0;
        while ((ps2_clk_oe || ps2_data_oe) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_sta", reg_sta_do, 32'd4);

        // Second write while the first frame is running must stall.
        host_write(8'hF4);
        nwait = 0;
        mism  = 0;
        fork
            device_frame(1'b1, 1'b0, -1, st, bits, par, sp);
            begin
                repeat (60) @(posedge clk);
                #1 reg_dat_we = 1'b1;
                reg_dat_di = {24'h123456, 8'h55};
                n = 0;
                while (n < 3000) begin
                    @(negedge clk);
                    if (reg_dat_wait !== tx_active) mism++;
                    if (!reg_dat_wait) break;
                    nwait++;
                    n++;
                end
                @(posedge clk);
                #1 reg_dat_we = 1'b0;
            end
        join
        chk("stall_first_bits", {24'b0, bits}, 32'hF4);
        chk("stall_first_par", {31'b0, par}, 32'd0);
        chk("stall_wait_long", {31'b0, (nwait >= 200)}, 32'd1);
        chk("stall_wait_eq_busy", mism, 32'd0);
        device_frame(1'b1, 1'b0, -1, st2, bits2, par2, sp2);
        wait_idle("stall_idle");
        @(negedge clk);
        chk("stall_second_bits", {24'b0, bits2}, 32'h55);
        chk("stall_second_par", {31'b0, par2}, 32'd1);
        chk("stall_second_sta", reg_sta_do, 32'd2);

        // Reset during bit 4, then a clean retry.
        host_write(8'hAA);
        device_frame(1'b1, 1'b0, 4, st, bits, par, sp);
        dev_data = 1'b1;
        repeat (10) @(posedge clk);
        run_frame("retry", 8'hAA, 1'b1, 1'b0, 1'b1, 32'd2);

        // Random bytes against a reference: parity makes total ones odd.
        for (int k = 0; k < 5; k++) begin
            logic [7:0] rb;
            bit         ra;
            logic       ep;
            rb = $urandom;
            ra = $urandom_range(0, 1);
            ep = (($countones(rb) % 2) == 0) ? 1'b1 : 1'b0;
            run_frame($sformatf("rnd%0d", k), rb, ra, 1'b0, ep, ra ? 32'd2 : 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
